// File: rtl/q299_layer_pipe.sv
// Shared Q299 quadratic layer for a 2-share Midori64 TI datapath, followed by a handshaked register pipeline.
// Optional mask refresh at stage 1 is enabled by defining Q299_REFRESH_EN (adds the rnd port).
module q299_layer_pipe #(
  parameter int NIBBLES    = 16,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_bypass,
  input  logic [4*NIBBLES-1:0]   in_sh_a,
  input  logic [4*NIBBLES-1:0]   in_sh_b,
`ifdef Q299_REFRESH_EN
  input  logic [4*NIBBLES-1:0]   rnd,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sh_a,
  output logic [4*NIBBLES-1:0]   out_sh_b
);

  localparam int W = 4 * NIBBLES;

  // Share-A part of a shared product xi*xj; the bi&bj part belongs to share B.
  function automatic logic prod_a(input logic ai, input logic aj, input logic bi, input logic bj);
    return (ai & aj) ^ (aj & bi) ^ (ai & bj);
  endfunction

  logic [W-1:0] map_a;
  logic [W-1:0] map_b;
  logic [W-1:0] stage_in_a;
  logic [W-1:0] stage_in_b;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_lane
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ya;
    logic [3:0] yb;
    logic       p03a, p13a, p23a;
    logic       p03b, p13b, p23b;

    assign a = in_sh_a[4*k +: 4];
    assign b = in_sh_b[4*k +: 4];

    assign p03a = prod_a(a[0], a[3], b[0], b[3]);
    assign p13a = prod_a(a[1], a[3], b[1], b[3]);
    assign p23a = prod_a(a[2], a[3], b[2], b[3]);
    assign p03b = b[0] & b[3];
    assign p13b = b[1] & b[3];
    assign p23b = b[2] & b[3];

    assign ya[3] = a[3];
    assign ya[2] = a[2] ^ p13a ^ p23a;
    assign ya[1] = a[1] ^ p03a ^ p13a ^ p23a;
    assign ya[0] = a[0] ^ p03a ^ p23a;

    assign yb[3] = b[3];
    assign yb[2] = b[2] ^ p13b ^ p23b;
    assign yb[1] = b[1] ^ p03b ^ p13b ^ p23b;
    assign yb[0] = b[0] ^ p03b ^ p23b;

    assign map_a[4*k +: 4] = in_bypass ? a : ya;
    assign map_b[4*k +: 4] = in_bypass ? b : yb;
  end

`ifdef Q299_REFRESH_EN
  // The same mask on both shares leaves the recombined value unchanged.
  assign stage_in_a = map_a ^ rnd;
  assign stage_in_b = map_b ^ rnd;
`else
  assign stage_in_a = map_a;
  assign stage_in_b = map_b;
`endif

  logic [PIPE_DEPTH-1:0] valid;
  logic [PIPE_DEPTH-1:0] stage_ready;
  logic [PIPE_DEPTH-1:0] load;
  logic [W-1:0]          data_a [PIPE_DEPTH];
  logic [W-1:0]          data_b [PIPE_DEPTH];

  // A stage may advance if downstream is accepting or any later stage is empty.
  always_comb begin
    stage_ready = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      logic acc;
      acc = out_ready;
      for (int j = i + 1; j < PIPE_DEPTH; j++) begin
        acc = acc | ~valid[j];
      end
      stage_ready[i] = acc;
    end
  end

  assign load     = ~valid | stage_ready;
  assign in_ready = load[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        data_a[i] <= '0;
        data_b[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid[0] <= in_valid;
        if (in_valid) begin
          data_a[0] <= stage_in_a;
          data_b[0] <= stage_in_b;
        end
      end
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        if (load[i]) begin
          valid[i] <= valid[i-1];
          if (valid[i-1]) begin
            data_a[i] <= data_a[i-1];
            data_b[i] <= data_b[i-1];
          end
        end
      end
    end
  end

  assign out_valid = valid[PIPE_DEPTH-1];
  assign out_sh_a  = data_a[PIPE_DEPTH-1];
  assign out_sh_b  = data_b[PIPE_DEPTH-1];

endmodule

// File: tb/tb_q299_layer_pipe.sv
// Self-checking bench for q299_layer_pipe: directed and random transactions against a nibble-level model
// with a scoreboard queue; define Q299_REFRESH_EN to also exercise the mask refresh.
module tb_q299_layer_pipe;

  localparam int NIB   = 16;
  localparam int DEPTH = 3;
  localparam int W     = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_bypass;
  logic [W-1:0] in_sh_a;
  logic [W-1:0] in_sh_b;
`ifdef Q299_REFRESH_EN
  logic [W-1:0] rnd;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sh_a;
  logic [W-1:0] out_sh_b;

  int           errors = 0;
  int           checks = 0;
  exp_t         q[$];
  logic [W-1:0] cur_sum;
  bit           rand_ready = 0;
  bit           stalled = 0;
  logic [W-1:0] prev_a, prev_b;

  q299_layer_pipe #(.NIBBLES(NIB), .PIPE_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bypass(in_bypass),
    .in_sh_a(in_sh_a),
    .in_sh_b(in_sh_b),
`ifdef Q299_REFRESH_EN
    .rnd(rnd),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sh_a(out_sh_a),
    .out_sh_b(out_sh_b)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Unshared layer: a nibble with the top bit clear is unchanged, otherwise {1, x1, x0^x2, x2}.
  function automatic logic [W-1:0] f_map(input logic [W-1:0] x);
    logic [W-1:0] y;
    logic [3:0]   n;
    for (int k = 0; k < NIB; k++) begin
      n = x[4*k +: 4];
      y[4*k +: 4] = n[3] ? {1'b1, n[1], n[0] ^ n[2], n[2]} : n;
    end
    return y;
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Share B is the unshared map of b alone; share A carries the rest of y(a^b).
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      exp_t e;
      checkOutput("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < DEPTH) || out_ready});
      if (stalled) begin
        checkOutput("stall_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("stall_sh_a", out_sh_a, prev_a);
        checkOutput("stall_sh_b", out_sh_b, prev_b);
      end
      if (out_valid && out_ready) begin
        checkOutput("unexpected_output", {63'd0, q.size() > 0}, 64'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          checkOutput("out_sh_a", out_sh_a, e.a);
          checkOutput("out_sh_b", out_sh_b, e.b);
          checkOutput("recombined", out_sh_a ^ out_sh_b, e.s);
        end
      end
      if (in_valid && in_ready) begin
        e.b = in_bypass ? in_sh_b : f_map(in_sh_b);
        e.a = in_bypass ? in_sh_a : f_map(in_sh_a ^ in_sh_b) ^ f_map(in_sh_b);
`ifdef Q299_REFRESH_EN
        e.a = e.a ^ rnd;
        e.b = e.b ^ rnd;
`endif
        e.s = cur_sum;
        q.push_back(e);
      end
      stalled = out_valid && !out_ready;
      prev_a  = out_sh_a;
      prev_b  = out_sh_b;
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic byp,
                               input logic [W-1:0] sum);
    int n;
    bit got;
    in_sh_a   = a;
    in_sh_b   = b;
    in_bypass = byp;
    cur_sum   = sum;
    in_valid  = 1;
    got = 0;
    n   = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (in_ready) got = 1;
      @(posedge clk);
      #1;
      n++;
      if (!got && rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    checkOutput("accept_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic drain();
    int n;
    in_valid  = 0;
    out_ready = 1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", W'(q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b, x;
    logic [W-1:0] bp_a [8];
    logic [W-1:0] bp_b [8];
    logic         byp;
    int           cycles, idx;

    $display("[TB] start");
    rst_n = 1; in_valid = 0; in_bypass = 0; in_sh_a = '0; in_sh_b = '0; out_ready = 1;
    cur_sum = '0;
`ifdef Q299_REFRESH_EN
    rnd = '0;
`endif
    #1 rst_n = 0;
    #2;
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_sh_a", out_sh_a, 64'd0);
    checkOutput("reset_sh_b", out_sh_b, 64'd0);
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // All-ones state through an idle pipe, with latency measurement
    a = rand64();
    applyStimulus(a, a ^ 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hDDDD_DDDD_DDDD_DDDD);
    in_valid = 0;
    cycles = 1;
    while (cycles < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      cycles++;
    end
    checkOutput("latency", W'(cycles), W'(DEPTH));
    drain();

    a = rand64();
    applyStimulus(a, a ^ 64'h0000_0000_BA87_0F7A, 0, 64'h0000_0000_EC87_0D7C);
    a = rand64();
    applyStimulus(a, a ^ 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();

`ifdef Q299_REFRESH_EN
    rnd = 64'h5555_5555_5555_5555;
    a = rand64();
    applyStimulus(a, a ^ 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hDDDD_DDDD_DDDD_DDDD);
    applyStimulus(a, a ^ 64'h0000_0000_BA87_0F7A, 1, 64'h0000_0000_BA87_0F7A);
    drain();
`endif

    // Random traffic with random back-pressure
    rand_ready = 1;
    for (int t = 0; t < 30; t++) begin
      a = rand64();
      b = rand64();
      byp = ($urandom_range(0, 4) == 0);
`ifdef Q299_REFRESH_EN
      rnd = rand64();
`endif
      applyStimulus(a, b, byp, byp ? (a ^ b) : f_map(a ^ b));
    end
    rand_ready = 0;
    drain();

    // Eight-transaction stream with a five-cycle downstream stall in the middle
    for (int t = 0; t < 8; t++) begin
      bp_a[t] = rand64();
      bp_b[t] = rand64();
    end
    idx = 0;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid  = 1;
      in_bypass = 0;
      in_sh_a   = bp_a[idx];
      in_sh_b   = bp_b[idx];
      cur_sum   = f_map(bp_a[idx] ^ bp_b[idx]);
      @(negedge clk);
      if (c == 7) checkOutput("in_ready_stalled", {63'd0, in_ready}, 64'd0);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    checkOutput("stream_accepted", W'(idx), 64'd8);
    drain();

    // Reset while the pipe is full and stalled
    out_ready = 0;
    for (int t = 0; t < DEPTH; t++) begin
      a = rand64();
      b = rand64();
      applyStimulus(a, b, 0, f_map(a ^ b));
    end
    checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #1 rst_n = 0;
    #1;
    checkOutput("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midreset_sh_a", out_sh_a, 64'd0);
    checkOutput("midreset_sh_b", out_sh_b, 64'd0);
    checkOutput("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    in_valid = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;

    a = rand64();
    b = rand64();
    applyStimulus(a, b, 0, f_map(a ^ b));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
